row_clear: RTL and testbench

Downstream consumer of the row-completion scanner in the falling-block game datapath. Owns the settled 14x18 playfield register and drives it back to the scanner. When the scanner flags a full row, it pauses the scanner, collapses that row by shifting every row above it down one row at a time, and keeps a running count of cleared lines. It signals completion once a full scanner pass finds no full rows.

---
 rtl/row_clear.sv | 179 +++++++++++++++++
 tb/tb_row_clear.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_clear.sv
`default_nettype none
// ============================================================================
//  Module   : row_clear
//  Purpose  : Owns the settled playfield. Pauses the row scanner whenever a
//             full row is flagged, collapses that row by shifting the rows
//             above it down one per cycle, counts cleared lines, and pulses
//             Clear_done once a complete scanner pass sees no full row.
//  Revision : 1.0  initial release
// ============================================================================
module row_clear #(
  parameter int BLOCKS_WIDE = 14,
  parameter int BLOCKS_HIGH = 18,
  parameter int LINES_W     = 16
) (
  input  logic                               Clk,
  input  logic                               Rst_n,
  input  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] Board_in,
  input  logic                               Load,
  input  logic [4:0]                         Row,
  input  logic                               Enabled,
  output logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] Game,
  output logic                               Pause,
  output logic                               Busy,
  output logic                               Clear_done,
  output logic [LINES_W-1:0]                 Lines
);

  // Row pointer and pass counter share the scanner's 5-bit row index width.
  localparam int                 c_PTR_W    = 5;
  localparam logic [c_PTR_W-1:0] c_LAST_ROW = c_PTR_W'(BLOCKS_HIGH - 1);
  localparam logic [c_PTR_W-1:0] c_NUM_ROWS = c_PTR_W'(BLOCKS_HIGH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_PTR_W-1:0]   r_ptr;
  logic [c_PTR_W-1:0]   r_pass;
  logic [LINES_W-1:0]   r_lines;
  logic                 r_clear_done;
  logic                 w_pause;
  logic                 w_busy;
  logic                 w_hit;
  logic                 w_pass_end;
  logic                 w_load_ok;
  logic                 w_ptr_zero;

  // An out-of-range row index from the scanner never counts as a full row.
  assign w_hit      = Enabled && (Row < c_NUM_ROWS);
  // The sample that brings the pass counter to BLOCKS_HIGH ends the pass.
  assign w_pass_end = (r_pass == c_LAST_ROW);
  assign w_load_ok  = (r_state == ST_IDLE) && Load;
  assign w_ptr_zero = (r_ptr == '0);

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs; scanner runs only in SCAN.
  always_comb begin
    w_state_nxt = r_state;
    w_pause     = 1'b1;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (Load) begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_pause = 1'b0;
        if (w_hit) begin
          w_state_nxt = ST_SHIFT;
        end else if (w_pass_end) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (w_ptr_zero) begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Row pointer: captured on a hit, walked up toward the top while shifting.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ptr <= '0;
    end else if (r_state == ST_SCAN && w_hit) begin
      r_ptr <= Row;
    end else if (r_state == ST_SHIFT && !w_ptr_zero) begin
      r_ptr <= r_ptr - 1'b1;
    end
  end

  // Pass counter: consecutive non-full samples since the last board change.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pass <= '0;
    end else if (w_load_ok) begin
      r_pass <= '0;
    end else if (r_state == ST_SCAN && !w_hit) begin
      r_pass <= r_pass + 1'b1;
    end else if (r_state == ST_SHIFT && w_ptr_zero) begin
      r_pass <= '0;
    end
  end

  // Cleared-line counter, saturating at all-ones.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_lines <= '0;
    end else if (r_state == ST_SCAN && w_hit && (r_lines != '1)) begin
      r_lines <= r_lines + LINES_W'(1);
    end
  end

  // Completion pulse: raised when a clean pass ends, dropped leaving DONE.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_clear_done <= 1'b0;
    end else if (r_state == ST_SCAN && !w_hit && w_pass_end) begin
      r_clear_done <= 1'b1;
    end else if (r_state == ST_DONE) begin
      r_clear_done <= 1'b0;
    end
  end

  // One register per playfield row; only the row at ptr is written in SHIFT,
  // taking the row above it (or zeros for the top row).
  for (genvar i = 0; i < BLOCKS_HIGH; i++) begin : g_row
    logic [BLOCKS_WIDE-1:0] r_row;
    logic [BLOCKS_WIDE-1:0] w_above;

    if (i == 0) begin : g_top
      assign w_above = '0;
    end else begin : g_body
      assign w_above = Game[BLOCKS_WIDE*(i-1) +: BLOCKS_WIDE];
    end

    // Row storage: load from Board_in in IDLE, shift down when selected.
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        r_row <= '0;
      end else if (w_load_ok) begin
        r_row <= Board_in[BLOCKS_WIDE*i +: BLOCKS_WIDE];
      end else if (r_state == ST_SHIFT && r_ptr == c_PTR_W'(i)) begin
        r_row <= w_above;
      end
    end

    assign Game[BLOCKS_WIDE*i +: BLOCKS_WIDE] = r_row;
  end

  assign Pause      = w_pause;
  assign Busy       = w_busy;
  assign Clear_done = r_clear_done;
  assign Lines      = r_lines;

endmodule
`default_nettype wire

// File: tb/tb_row_clear.sv
`default_nettype none
// ============================================================================
//  Module   : tb_row_clear
//  Purpose  : Self-checking bench for row_clear. A small scanner model feeds
//             Row/Enabled from the live board; each Load pushes the expected
//             settled board, line count and timing into a scoreboard that a
//             separate monitor checks when Clear_done appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_row_clear;

  localparam int W  = 14;
  localparam int H  = 18;
  localparam int BW = W * H;

  logic            Clk      = 1'b0;
  logic            Rst_n    = 1'b1;
  logic [BW-1:0]   Board_in = '0;
  logic            Load     = 1'b0;
  logic [4:0]      Row;
  logic            Enabled;
  logic [BW-1:0]   Game;
  logic            Pause;
  logic            Busy;
  logic            Clear_done;
  logic [15:0]     Lines;
  logic [BW-1:0]   Game_s;
  logic            Pause_s;
  logic            Busy_s;
  logic            Done_s;
  logic [1:0]      Lines_s;

  always #5 Clk = ~Clk;

  row_clear #(.BLOCKS_WIDE(W), .BLOCKS_HIGH(H), .LINES_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Board_in(Board_in), .Load(Load), .Row(Row),
    .Enabled(Enabled), .Game(Game), .Pause(Pause), .Busy(Busy),
    .Clear_done(Clear_done), .Lines(Lines)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  row_clear #(.BLOCKS_WIDE(W), .BLOCKS_HIGH(H), .LINES_W(2)) dut_s (
    .Clk(Clk), .Rst_n(Rst_n), .Board_in(Board_in), .Load(Load), .Row(Row),
    .Enabled(Enabled), .Game(Game_s), .Pause(Pause_s), .Busy(Busy_s),
    .Clear_done(Done_s), .Lines(Lines_s)
  );

  // Scanner model: walks rows 0..H-1 cyclically while not paused.
  logic [4:0] scan_row;
  logic       phase_req = 1'b0;
  logic [4:0] phase_val = '0;
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)          scan_row <= '0;
    else if (!Pause)     scan_row <= (scan_row == 5'(H-1)) ? 5'd0 : scan_row + 5'd1;
    else if (phase_req)  scan_row <= phase_val;
  end
  assign Row     = scan_row;
  assign Enabled = (int'(scan_row) < H) && (&Game[W*scan_row +: W]);

  typedef struct {
    logic [BW-1:0] game;
    int            lines;
    int            cycles;
    int            shifts;
  } exp_t;

  exp_t sb[$];
  int   checks      = 0;
  int   failures    = 0;
  int   total_lines = 0;
  bit   mon_en      = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: scan cyclically from pos; each full row found is removed and
  // everything above drops one row; scanning resumes on the row after the hit.
  function automatic void model(input logic [BW-1:0] brd, input int pos0,
                                output logic [BW-1:0] fin, output int n,
                                output int cyc, output int sh);
    logic [W-1:0] b [H];
    int pos, hit, k_at, r;
    for (int i = 0; i < H; i++) b[i] = brd[W*i +: W];
    pos = pos0; n = 0; cyc = 0; sh = 0;
    for (int guard = 0; guard <= H; guard++) begin
      hit = -1; k_at = 0;
      for (int k = 0; k < H; k++) begin
        r = (pos + k) % H;
        if (hit < 0 && (&b[r])) begin hit = r; k_at = k; end
      end
      if (hit < 0) begin
        cyc += H;
        break;
      end
      cyc += k_at + 1 + hit + 1;
      sh  += hit + 1;
      for (int j = hit; j > 0; j--) b[j] = b[j-1];
      b[0] = '0;
      n++;
      pos = (hit + 1) % H;
    end
    for (int i = 0; i < H; i++) fin[W*i +: W] = b[i];
  endfunction

  function automatic logic [BW-1:0] rand_board(input int full_pct);
    logic [BW-1:0] b;
    int s;
    for (int i = 0; i < H; i++) begin
      s = int'($urandom_range(99));
      if (s < full_pct)           b[W*i +: W] = '1;
      else if (s < full_pct + 20) b[W*i +: W] = '0;
      else                        b[W*i +: W] = W'($urandom);
    end
    return b;
  endfunction

  // Monitor: times each busy period and checks the scoreboard on Clear_done.
  int   busy_cnt  = 0;
  int   pause_cnt = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  exp_t e_mon;
  always @(negedge Clk) begin
    if (!Rst_n || !mon_en) begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (Busy && !prev_busy) begin busy_cnt = 0; pause_cnt = 0; end
      if (Busy) busy_cnt++;
      if (Busy && Pause) pause_cnt++;
      if (prev_done) begin
        chk("done_one_cycle", Clear_done, 0);
        chk("idle_after_done", Busy, 0);
      end
      if (Clear_done && !prev_done) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got Clear_done=1 expected no pulse");
        end else begin
          e_mon = sb.pop_front();
          chk("final_board", Game, e_mon.game);
          chk("lines", Lines, e_mon.lines);
          chk("sat_lines", Lines_s, (e_mon.lines > 3) ? 3 : e_mon.lines);
          chk("sat_board", Game_s, e_mon.game);
          chk("busy_cycles", busy_cnt, e_mon.cycles);
          chk("paused_cycles", pause_cnt, e_mon.shifts);
        end
      end
      prev_busy = Busy;
      prev_done = Clear_done;
    end
  end

  task automatic set_phase(input int phase);
    @(negedge Clk);
    phase_val = 5'(phase);
    phase_req = 1'b1;
    @(negedge Clk);
    phase_req = 1'b0;
  endtask

  task automatic do_load(input logic [BW-1:0] brd, input int phase,
                         input bit ghost_en, input logic [BW-1:0] ghost);
    logic [BW-1:0] fin;
    int n, cyc, sh;
    exp_t e_push;
    set_phase(phase);
    model(brd, phase, fin, n, cyc, sh);
    total_lines += n;
    e_push.game   = fin;
    e_push.lines  = total_lines;
    e_push.cycles = cyc + 1;
    e_push.shifts = sh + 1;
    sb.push_back(e_push);
    Board_in = brd;
    Load     = 1'b1;
    @(negedge Clk);
    Load     = 1'b0;
    Board_in = rand_board(50);
    if (ghost_en) begin
      for (int t = 0; t < 100 && !(Busy && Pause); t++) @(negedge Clk);
      if (Busy && Pause) begin
        Board_in = ghost;
        Load     = 1'b1;
        @(negedge Clk);
        Load     = 1'b0;
        chk("ghost_ignored", Game == ghost, 0);
      end
    end
    for (int t = 0; t < 2000 && Busy; t++) @(negedge Clk);
    chk("finish_in_time", Busy, 0);
    repeat (3) @(negedge Clk);
    chk("idle_hold", Game, fin);
  endtask

  logic [BW-1:0] brd;

  initial begin
    // Asynchronous reset asserted mid-cycle.
    #7 Rst_n = 1'b0;
    #1;
    chk("rst_game", Game, 0);
    chk("rst_lines", Lines, 0);
    chk("rst_pause", Pause, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Clear_done, 0);
    chk("rst_sat_lines", Lines_s, 0);
    repeat (2) @(negedge Clk);
    Rst_n  = 1'b1;
    mon_en = 1'b1;

    // Empty board.
    do_load('0, 0, 1'b0, '0);

    // Single full bottom row with a partial row above it.
    brd = '0;
    brd[W*17 +: W] = '1;
    brd[W*16 +: W] = 14'h0005;
    do_load(brd, 0, 1'b0, '0);
    chk("bottom_row17", Game[W*17 +: W], 14'h0005);

    // Two stacked full rows.
    brd = '0;
    brd[W*16 +: W] = '1;
    brd[W*17 +: W] = '1;
    brd[W*15 +: W] = 14'h2001;
    do_load(brd, 0, 1'b0, '0);
    chk("stacked_row17", Game[W*17 +: W], 14'h2001);

    // Full top row, with a second Load during SHIFT.
    brd = '0;
    brd[W*0 +: W] = '1;
    do_load(brd, 0, 1'b1, rand_board(10));
    chk("top_row0", Game[W*0 +: W], 14'h0000);

    // Reset while the bottom row is being collapsed.
    set_phase(0);
    brd = '0;
    brd[W*17 +: W] = '1;
    brd[W*3 +: W]  = 14'h1234;
    Board_in = brd;
    Load     = 1'b1;
    @(negedge Clk);
    Load     = 1'b0;
    for (int t = 0; t < 100 && !(Busy && Pause); t++) @(negedge Clk);
    chk("reached_shift", Busy && Pause, 1);
    repeat (5) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("mid_rst_game", Game, 0);
    chk("mid_rst_lines", Lines, 0);
    chk("mid_rst_pause", Pause, 1);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_done", Clear_done, 0);
    sb.delete();
    total_lines = 0;
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (40) @(negedge Clk);
    chk("post_rst_idle", Busy, 0);
    chk("post_rst_game", Game, 0);

    // Four full rows: narrow counter saturates at 3.
    brd = rand_board(0);
    for (int i = 14; i < 18; i++) brd[W*i +: W] = '1;
    do_load(brd, 5, 1'b0, '0);
    chk("sat_hold", Lines_s, 2'b11);
    chk("wide_lines4", Lines, 16'd4);

    // Randomized boards, scanner phases and stray Loads.
    for (int it = 0; it < 30; it++) begin
      do_load(rand_board(int'($urandom_range(10, 45))), int'($urandom_range(H-1)),
              1'($urandom_range(1)), rand_board(30));
    end

    chk("queue_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
